m2_block_scheduler: RTL

M2_BLOCK_SCHEDULER -- requirements
Module: m2_block_scheduler

---
 rtl/m2_block_scheduler_pkg.sv | 32 +++
 rtl/m2_block_counter.sv | 70 +++++++
 rtl/m2_block_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/m2_block_scheduler_pkg.sv
// Shared constants for the M2 block scheduler: FSM state codes, plane codes,
// default block-grid dimensions and a helper giving the last column of a plane.
// No ports; imported by m2_block_scheduler and m2_block_counter.
package m2_block_scheduler_pkg;

  // Default block grid: 320x240 Y plane and 160x240 U/V planes in 8x8 blocks.
  localparam int Y_COLS_DEF   = 40;
  localparam int UV_COLS_DEF  = 20;
  localparam int BLK_ROWS_DEF = 30;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_LI_FETCH = 3'd1;
  localparam state_t S_LI_CT    = 3'd2;
  localparam state_t S_MEGA_A   = 3'd3;
  localparam state_t S_MEGA_B   = 3'd4;
  localparam state_t S_LO_CS    = 3'd5;
  localparam state_t S_LO_WRITE = 3'd6;

  localparam logic [1:0] PLANE_Y = 2'd0;
  localparam logic [1:0] PLANE_U = 2'd1;
  localparam logic [1:0] PLANE_V = 2'd2;

  // Index of the last block column in the given plane.
  function automatic logic [5:0] col_last(input logic [1:0] plane,
                                          input int        y_cols,
                                          input int        uv_cols);
    return (plane == PLANE_Y) ? 6'(y_cols - 1) : 6'(uv_cols - 1);
  endfunction

endpackage

// File: rtl/m2_block_counter.sv
// Block position counter: walks (plane,row,col) in Y,U,V order, row-major,
// and flags the final block of the V plane.
// Ports: Clock/resetn, clear_i (back to Y 0,0), adv_i (step one block),
// plane_o/row_o/col_o current position, last_o high on the last block.
module m2_block_counter
  import m2_block_scheduler_pkg::*;
#(
  parameter int Y_COLS   = Y_COLS_DEF,
  parameter int UV_COLS  = UV_COLS_DEF,
  parameter int BLK_ROWS = BLK_ROWS_DEF
) (
  input  logic       Clock,
  input  logic       resetn,
  input  logic       clear_i,
  input  logic       adv_i,
  output logic [1:0] plane_o,
  output logic [5:0] row_o,
  output logic [5:0] col_o,
  output logic       last_o
);

  logic [1:0] plane_q, plane_d;
  logic [5:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic [5:0] col_max;
  logic [5:0] row_max;

  always_comb begin
    col_max = col_last(plane_q, Y_COLS, UV_COLS);
    row_max = 6'(BLK_ROWS - 1);
    plane_d = plane_q;
    row_d   = row_q;
    col_d   = col_q;
    if (clear_i) begin
      plane_d = PLANE_Y;
      row_d   = '0;
      col_d   = '0;
    end else if (adv_i) begin
      if (col_q != col_max) begin
        col_d = col_q + 6'd1;
      end else begin
        col_d = '0;
        if (row_q != row_max) begin
          row_d = row_q + 6'd1;
        end else begin
          row_d   = '0;
          plane_d = (plane_q == PLANE_V) ? PLANE_Y : plane_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      plane_q <= PLANE_Y;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      plane_q <= plane_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign plane_o = plane_q;
  assign row_o   = row_q;
  assign col_o   = col_q;
  assign last_o  = (plane_q == PLANE_V) && (row_q == row_max) && (col_q == col_max);

endmodule

// File: rtl/m2_block_scheduler.sv
// Pipelined block scheduler: overlaps fetch(k+1)/CS(k) and CT(k+1)/write(k)
// across all Y,U,V blocks, then drains the last block and pulses done.
// Ports: start/done frame handshake; *_start pulses and *_done pulses per unit;
// fetch/write block coordinates and plane; fetch/write SRAM requests muxed onto sram_*.
module m2_block_scheduler
  import m2_block_scheduler_pkg::*;
#(
  parameter int Y_COLS   = Y_COLS_DEF,
  parameter int UV_COLS  = UV_COLS_DEF,
  parameter int BLK_ROWS = BLK_ROWS_DEF
) (
  input  logic        Clock,
  input  logic        resetn,
  input  logic        start,
  output logic        done,
  output logic        fetch_start,
  output logic        ct_start,
  output logic        cs_start,
  output logic        write_start,
  input  logic        fetch_done,
  input  logic        ct_done,
  input  logic        cs_done,
  input  logic        write_done,
  output logic [5:0]  fetch_block_row,
  output logic [5:0]  fetch_block_col,
  output logic [5:0]  write_block_row,
  output logic [5:0]  write_block_col,
  output logic [1:0]  fetch_plane,
  output logic [1:0]  write_plane,
  input  logic [17:0] fetch_sram_address,
  input  logic        fetch_sram_we_n,
  input  logic [15:0] fetch_sram_wdata,
  input  logic [17:0] write_sram_address,
  input  logic        write_sram_we_n,
  input  logic [15:0] write_sram_wdata,
  output logic [17:0] sram_address,
  output logic        sram_we_n,
  output logic [15:0] sram_wdata
);

  state_t state_q, state_d;
  logic   fetch_start_q, fetch_start_d;
  logic   ct_start_q, ct_start_d;
  logic   cs_start_q, cs_start_d;
  logic   write_start_q, write_start_d;
  logic   done_q, done_d;
  // seen_a: cs_done (MEGA_A) / ct_done (MEGA_B); seen_b: fetch_done / write_done.
  logic   seen_a_q, seen_a_d;
  logic   seen_b_q, seen_b_d;
  logic   hit_a, hit_b;
  logic   cnt_clear, fcnt_adv, wcnt_adv;
  logic   fcnt_last, wcnt_last;

  // Fetch counter runs one block ahead of the write counter (k+1 vs k).
  m2_block_counter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .BLK_ROWS(BLK_ROWS)) u_fetch_cnt (
    .Clock   (Clock),
    .resetn  (resetn),
    .clear_i (cnt_clear),
    .adv_i   (fcnt_adv),
    .plane_o (fetch_plane),
    .row_o   (fetch_block_row),
    .col_o   (fetch_block_col),
    .last_o  (fcnt_last)
  );

  m2_block_counter #(.Y_COLS(Y_COLS), .UV_COLS(UV_COLS), .BLK_ROWS(BLK_ROWS)) u_write_cnt (
    .Clock   (Clock),
    .resetn  (resetn),
    .clear_i (cnt_clear),
    .adv_i   (wcnt_adv),
    .plane_o (write_plane),
    .row_o   (write_block_row),
    .col_o   (write_block_col),
    .last_o  (wcnt_last)
  );

  always_comb begin
    state_d       = state_q;
    fetch_start_d = 1'b0;
    ct_start_d    = 1'b0;
    cs_start_d    = 1'b0;
    write_start_d = 1'b0;
    done_d        = 1'b0;
    seen_a_d      = seen_a_q;
    seen_b_d      = seen_b_q;
    hit_a         = 1'b0;
    hit_b         = 1'b0;
    cnt_clear     = 1'b0;
    fcnt_adv      = 1'b0;
    wcnt_adv      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_LI_FETCH;
          fetch_start_d = 1'b1;
          cnt_clear     = 1'b1;
          seen_a_d      = 1'b0;
          seen_b_d      = 1'b0;
        end
      end
      S_LI_FETCH: begin
        if (fetch_done) begin
          state_d    = S_LI_CT;
          ct_start_d = 1'b1;
        end
      end
      S_LI_CT: begin
        if (ct_done) begin
          cs_start_d = 1'b1;
          // Write counter still sits on block 0: last here means a one-block frame.
          if (wcnt_last) begin
            state_d = S_LO_CS;
          end else begin
            state_d       = S_MEGA_A;
            fetch_start_d = 1'b1;
            fcnt_adv      = 1'b1;
          end
        end
      end
      S_MEGA_A: begin
        hit_a = seen_a_q | cs_done;
        hit_b = seen_b_q | fetch_done;
        if (hit_a && hit_b) begin
          state_d       = S_MEGA_B;
          ct_start_d    = 1'b1;
          write_start_d = 1'b1;
          seen_a_d      = 1'b0;
          seen_b_d      = 1'b0;
        end else begin
          seen_a_d = hit_a;
          seen_b_d = hit_b;
        end
      end
      S_MEGA_B: begin
        hit_a = seen_a_q | ct_done;
        hit_b = seen_b_q | write_done;
        if (hit_a && hit_b) begin
          seen_a_d   = 1'b0;
          seen_b_d   = 1'b0;
          wcnt_adv   = 1'b1;
          cs_start_d = 1'b1;
          // The new k equals the fetch position; if that was the last block,
          // nothing remains to fetch and the pipeline drains.
          if (fcnt_last) begin
            state_d = S_LO_CS;
          end else begin
            state_d       = S_MEGA_A;
            fetch_start_d = 1'b1;
            fcnt_adv      = 1'b1;
          end
        end else begin
          seen_a_d = hit_a;
          seen_b_d = hit_b;
        end
      end
      S_LO_CS: begin
        if (cs_done) begin
          state_d       = S_LO_WRITE;
          write_start_d = 1'b1;
        end
      end
      S_LO_WRITE: begin
        if (write_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      fetch_start_q <= 1'b0;
      ct_start_q    <= 1'b0;
      cs_start_q    <= 1'b0;
      write_start_q <= 1'b0;
      done_q        <= 1'b0;
      seen_a_q      <= 1'b0;
      seen_b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_start_q <= fetch_start_d;
      ct_start_q    <= ct_start_d;
      cs_start_q    <= cs_start_d;
      write_start_q <= write_start_d;
      done_q        <= done_d;
      seen_a_q      <= seen_a_d;
      seen_b_q      <= seen_b_d;
    end
  end

  assign fetch_start = fetch_start_q;
  assign ct_start    = ct_start_q;
  assign cs_start    = cs_start_q;
  assign write_start = write_start_q;
  assign done        = done_q;

  // SRAM ownership follows the phase, so fetch and write can never collide.
  always_comb begin
    sram_address = '0;
    sram_we_n    = 1'b1;
    sram_wdata   = '0;
    case (state_q)
      S_LI_FETCH, S_MEGA_A: begin
        sram_address = fetch_sram_address;
        sram_we_n    = fetch_sram_we_n;
        sram_wdata   = fetch_sram_wdata;
      end
      S_MEGA_B, S_LO_WRITE: begin
        sram_address = write_sram_address;
        sram_we_n    = write_sram_we_n;
        sram_wdata   = write_sram_wdata;
      end
      default: ;
    endcase
  end

endmodule
